uart_cmd_responder: RTL and testbench

//  Host-side responder on the far end of the uart parallel byte interface (data_i/data_o, write/ack, busy/ready).

---
 rtl/uart_cmd_pkg.sv | 26 ++
 rtl/uart_cmd_if.sv | 21 ++
 rtl/uart_cmd_regfile.sv | 32 +++
 rtl/uart_cmd_responder.sv | 135 +++++++++++++
 tb/tb_uart_cmd_responder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM state type for the UART register peek/poke responder.
package uart_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OP_REL,
        ST_GET_ADDR,
        ST_ADDR_REL,
        ST_GET_DATA,
        ST_DATA_REL,
        ST_EXEC,
        ST_TX_REQ,
        ST_TX_START,
        ST_TX_DONE
    } state_t;

    function automatic logic addr_valid(input logic [7:0] addr, input int unsigned num_regs);
        return 32'(addr) < num_regs;
    endfunction

endpackage

// File: rtl/uart_cmd_if.sv
// Parallel byte handshake between the uart top (slave) and the command responder (master).
interface uart_cmd_if;

    logic [7:0] uart_rx_data_i;
    logic       uart_ready_i;
    logic       uart_ack_n_o;
    logic [7:0] uart_tx_data_o;
    logic       uart_write_n_o;
    logic       uart_busy_i;

    modport master (
        input  uart_rx_data_i, uart_ready_i, uart_busy_i,
        output uart_ack_n_o, uart_tx_data_o, uart_write_n_o
    );

    modport slave (
        output uart_rx_data_i, uart_ready_i, uart_busy_i,
        input  uart_ack_n_o, uart_tx_data_o, uart_write_n_o
    );

endinterface

// File: rtl/uart_cmd_regfile.sv
// NUM_REGS x 8-bit register file with single write port, one combinational read port and flat output.
module uart_cmd_regfile #(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [7:0]              addr,
    input  logic [7:0]              wdata,
    output logic [7:0]              rd_data,
    output logic [8*NUM_REGS-1:0]   regs
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (we) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (32'(addr) == k) regs[8*k +: 8] <= wdata;
            end
        end
    end

    // Out-of-range addresses read as zero; the FSM never returns them.
    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (32'(addr) == k) rd_data = regs[8*k +: 8];
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Command responder: 'W' addr data / 'R' addr over the uart byte handshake, answers 'K', data or '?'.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 520800
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    uart_cmd_if.master              uart,
    output logic [8*NUM_REGS-1:0]   regs_o,
    output logic                    cmd_err_o
);

    state_t     state;
    logic [7:0] opcode;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd_data;
    logic       is_write;
    logic       is_read;
    logic       cmd_bad;
    logic       reg_we;
    logic       tmo_hit;

    assign is_write = (opcode == OP_WRITE);
    assign is_read  = (opcode == OP_READ);
    assign cmd_bad  = !(is_write || is_read) || !addr_valid(addr, NUM_REGS);
    assign reg_we   = (state == ST_EXEC) && is_write && !cmd_bad;

    uart_cmd_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk     (clock_i),
        .rst_n   (reset_i),
        .we      (reg_we),
        .addr    (addr),
        .wdata   (wdata),
        .rd_data (rd_data),
        .regs    (regs_o)
    );

`ifdef UART_CMD_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        in_get;

    assign in_get  = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
    assign tmo_hit = in_get && (tmo_cnt >= 32'(TIMEOUT_CYCLES) - 32'd1);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            tmo_cnt <= '0;
        end else if (!uart.uart_ack_n_o || state == ST_IDLE) begin
            tmo_cnt <= '0;
        end else if (in_get) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state               <= ST_IDLE;
            opcode              <= '0;
            addr                <= '0;
            wdata               <= '0;
            uart.uart_ack_n_o   <= 1'b1;
            uart.uart_write_n_o <= 1'b1;
            uart.uart_tx_data_o <= '0;
            cmd_err_o           <= 1'b0;
        end else begin
            // Strobes default inactive so every assertion below lasts exactly one cycle.
            uart.uart_ack_n_o   <= 1'b1;
            uart.uart_write_n_o <= 1'b1;
            cmd_err_o           <= 1'b0;
            case (state)
                ST_IDLE: if (uart.uart_ready_i) begin
                    opcode            <= uart.uart_rx_data_i;
                    uart.uart_ack_n_o <= 1'b0;
                    state             <= ST_OP_REL;
                end
                ST_OP_REL: if (!uart.uart_ready_i) begin
                    if (is_write || is_read) begin
                        state <= ST_GET_ADDR;
                    end else begin
                        cmd_err_o <= 1'b1;
                        state     <= ST_EXEC;
                    end
                end
                ST_GET_ADDR: if (tmo_hit) begin
                    cmd_err_o <= 1'b1;
                    state     <= ST_IDLE;
                end else if (uart.uart_ready_i) begin
                    addr              <= uart.uart_rx_data_i;
                    uart.uart_ack_n_o <= 1'b0;
                    state             <= ST_ADDR_REL;
                end
                ST_ADDR_REL: if (!uart.uart_ready_i) begin
                    if (is_write) begin
                        state <= ST_GET_DATA;
                    end else begin
                        cmd_err_o <= cmd_bad;
                        state     <= ST_EXEC;
                    end
                end
                ST_GET_DATA: if (tmo_hit) begin
                    cmd_err_o <= 1'b1;
                    state     <= ST_IDLE;
                end else if (uart.uart_ready_i) begin
                    wdata             <= uart.uart_rx_data_i;
                    uart.uart_ack_n_o <= 1'b0;
                    state             <= ST_DATA_REL;
                end
                ST_DATA_REL: if (!uart.uart_ready_i) begin
                    cmd_err_o <= cmd_bad;
                    state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    uart.uart_tx_data_o <= cmd_bad  ? RSP_ERR :
                                           is_write ? RSP_OK  : rd_data;
                    state               <= ST_TX_REQ;
                end
                ST_TX_REQ: if (!uart.uart_busy_i) begin
                    uart.uart_write_n_o <= 1'b0;
                    state               <= ST_TX_START;
                end
                ST_TX_START: if (uart.uart_busy_i) state <= ST_TX_DONE;
                ST_TX_DONE:  if (!uart.uart_busy_i) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: directed commands against a register/response model.
module tb_uart_cmd_responder;

    localparam int unsigned NR = 16;
`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned TMO = 100;
`else
    localparam int unsigned TMO = 520800;
`endif

    logic            clk = 1'b0;
    logic            reset_i = 1'b0;
    logic [8*NR-1:0] regs_o;
    logic            cmd_err_o;
    logic            tx_busy = 1'b0;
    logic            hold_busy = 1'b0;

    uart_cmd_if u ();
    assign u.uart_busy_i = tx_busy | hold_busy;

    uart_cmd_responder #(.NUM_REGS(NR), .TIMEOUT_CYCLES(TMO)) dut (
        .clock_i   (clk),
        .reset_i   (reset_i),
        .uart      (u),
        .regs_o    (regs_o),
        .cmd_err_o (cmd_err_o)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         strobe_cnt = 0;
    int         ack_cnt = 0;
    int         err_pending = 0;
    int         inflight = 0;
    logic [7:0] last_tx = '0;
    logic [7:0] mregs [NR];
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Specification-level model: what the response byte and register contents must be.
    task automatic model_push(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
        if ((op == 8'h57 || op == 8'h52) && 32'(a) < NR) begin
            if (op == 8'h57) begin
                mregs[a] = d;
                exp_q.push_back(8'h4B);
            end else begin
                exp_q.push_back(mregs[a]);
            end
        end else begin
            exp_q.push_back(8'h3F);
            err_pending++;
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    logic prev_ack = 1'b0, prev_wr = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        if (!reset_i) begin
            inflight = 0;
            prev_ack = 1'b0; prev_wr = 1'b0; prev_err = 1'b0;
        end else begin
            if (inflight > 0) begin
                chk("tx_data_stable", u.uart_tx_data_o, last_tx);
                inflight--;
            end
            if (!u.uart_write_n_o) begin
                chk("write_strobe_width", prev_wr, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1'b1, 1'b0);
                end else begin
                    chk("tx_data", u.uart_tx_data_o, exp_q.pop_front());
                end
                strobe_cnt++;
                last_tx  = u.uart_tx_data_o;
                inflight = 12;
            end
            if (!u.uart_ack_n_o) begin
                chk("ack_width", prev_ack, 1'b0);
                ack_cnt++;
            end
            if (cmd_err_o) begin
                chk("cmd_err_width", prev_err, 1'b0);
                chk("cmd_err_expected", err_pending > 0, 1'b1);
                if (err_pending > 0) err_pending--;
            end
            prev_ack = !u.uart_ack_n_o;
            prev_wr  = !u.uart_write_n_o;
            prev_err = cmd_err_o;
        end
    end

    // Transmitter model: busy rises two cycles after a strobe and stays high for eight.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_i && !u.uart_write_n_o) begin
                repeat (2) @(negedge clk);
                tx_busy = 1'b1;
                repeat (8) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        @(negedge clk);
        u.uart_rx_data_i = b;
        u.uart_ready_i   = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (!u.uart_ack_n_o) got = 1;
        end
        if (!got) chk("ack_timeout", 1'b0, 1'b1);
        u.uart_ready_i = 1'b0;
    endtask

    task automatic check_regs();
        logic [8*NR-1:0] e;
        for (int k = 0; k < NR; k++) e[8*k +: 8] = mregs[k];
        chk("regs_o", regs_o, e);
    endtask

    task automatic wait_idle(input int target);
        bit done = 0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            if (strobe_cnt >= target && !tx_busy && inflight == 0) done = 1;
        end
        repeat (3) @(negedge clk);
        chk("strobe_count", strobe_cnt, target);
        chk("err_pending", err_pending, 0);
        chk("resp_queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
        int target = strobe_cnt + 1;
        model_push(op, a, d);
        send_byte(op);
        if (op == 8'h57 || op == 8'h52) send_byte(a);
        if (op == 8'h57) send_byte(d);
        wait_idle(target);
        check_regs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, s0;
        for (int k = 0; k < NR; k++) mregs[k] = '0;
        u.uart_rx_data_i = '0;
        u.uart_ready_i   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack_n", u.uart_ack_n_o, 1'b1);
        chk("rst_write_n", u.uart_write_n_o, 1'b1);
        chk("rst_tx_data", u.uart_tx_data_o, 8'h00);
        chk("rst_regs", regs_o, '0);
        chk("rst_cmd_err", cmd_err_o, 1'b0);
        reset_i = 1'b1;
        repeat (2) @(negedge clk);

        a0 = ack_cnt;
        run_cmd(8'h57, 8'h03, 8'hA5);
        chk("pin_reg3", regs_o[31:24], 8'hA5);
        chk("pin_resp_K", last_tx, 8'h4B);
        chk("pin_three_acks", ack_cnt - a0, 3);

        run_cmd(8'h52, 8'h03, 8'h00);
        chk("pin_read_A5", last_tx, 8'hA5);
        run_cmd(8'h52, 8'h10, 8'h00);
        chk("pin_bad_addr", last_tx, 8'h3F);
        run_cmd(8'h41, 8'h00, 8'h00);
        chk("pin_bad_op", last_tx, 8'h3F);
        run_cmd(8'h52, 8'h00, 8'h00);
        chk("pin_resync_read", last_tx, 8'h00);

        run_cmd(8'h57, 8'h0F, 8'h3C);
        run_cmd(8'h57, 8'h10, 8'h99);
        run_cmd(8'h52, 8'h0F, 8'h00);
        chk("pin_read_top", last_tx, 8'h3C);
        run_cmd(8'h57, 8'h00, 8'hFF);
        run_cmd(8'h52, 8'h00, 8'h00);

        // Transmitter held busy: no strobe, and a waiting byte is not accepted.
        hold_busy = 1'b1;
        s0 = strobe_cnt;
        model_push(8'h52, 8'h03, 8'h00);
        send_byte(8'h52);
        send_byte(8'h03);
        repeat (10) @(negedge clk);
        a0 = ack_cnt;
        u.uart_rx_data_i = 8'h52;
        u.uart_ready_i   = 1'b1;
        repeat (1000) @(negedge clk);
        chk("busy_hold_no_strobe", strobe_cnt, s0);
        chk("busy_hold_no_ack", ack_cnt, a0);
        hold_busy = 1'b0;
        model_push(8'h52, 8'h0F, 8'h00);
        send_byte(8'h52);
        send_byte(8'h0F);
        wait_idle(s0 + 2);
        chk("pin_after_hold", last_tx, 8'h3C);

`ifdef UART_CMD_TIMEOUT_EN
        s0 = strobe_cnt;
        err_pending++;
        send_byte(8'h57);
        repeat (TMO + 20) @(negedge clk);
        chk("timeout_err", err_pending, 0);
        chk("timeout_no_strobe", strobe_cnt, s0);
        run_cmd(8'h52, 8'h03, 8'h00);
`endif

        // Reset while the response is in flight.
        s0 = strobe_cnt;
        model_push(8'h57, 8'h05, 8'h77);
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'h77);
        for (int i = 0; i < 3000 && strobe_cnt == s0; i++) @(negedge clk);
        chk("reset_test_strobe", strobe_cnt, s0 + 1);
        #1 reset_i = 1'b0;
        #1;
        chk("async_ack_n", u.uart_ack_n_o, 1'b1);
        chk("async_write_n", u.uart_write_n_o, 1'b1);
        chk("async_tx_data", u.uart_tx_data_o, 8'h00);
        chk("async_regs", regs_o, '0);
        chk("async_cmd_err", cmd_err_o, 1'b0);
        for (int k = 0; k < NR; k++) mregs[k] = '0;
        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        wait_idle(strobe_cnt);
        run_cmd(8'h52, 8'h03, 8'h00);
        chk("pin_cleared_reg3", last_tx, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
